// File: rtl/sfifo_ctrl_pkg.sv
// Shared definitions for the threshold-FIFO control blocks: drain FSM states
// and the maximum-burst helper.
package sfifo_ctrl_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } drain_state_t;

    // MAXBURST = 1 << LGMAXBURST, usable from any parameterisation.
    function automatic int maxburst(input int lg);
        return 1 << lg;
    endfunction

endpackage

// File: rtl/burst_idle_timer.sv
// Saturating idle counter with clear/enable and a programmable limit;
// a limit of zero means the timeout never fires.
module burst_idle_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_hit
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && (count_q < i_limit)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_hit = (i_limit != '0) && (count_q == i_limit);

endmodule

// File: rtl/sfifo_burst_drain.sv
// Drain controller: turns FIFO fill level, idle timeout and flush requests
// into bounded bursts on a valid/ready stream fed from the FIFO head.
module sfifo_burst_drain
    import sfifo_ctrl_pkg::*;
#(
    parameter int BW         = 8,
    parameter int LGFLEN     = 4,
    parameter int LGMAXBURST = 4,
    parameter int LGTIMEOUT  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  logic [LGFLEN:0]   i_threshold,
    input  logic [LGTIMEOUT-1:0] i_timeout,
    input  logic              i_flush,
    input  logic [LGFLEN:0]   i_fill,
    input  logic              i_empty,
    input  logic [BW-1:0]     i_fdata,
    output logic              o_rd,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BW-1:0]     o_data,
    output logic              o_last,
    output logic              o_busy
);

    localparam int                LENW     = LGMAXBURST + 1;
    localparam int                MAXBURST = maxburst(LGMAXBURST);
    localparam logic [LGFLEN:0]   MAXFILL  = (LGFLEN + 1)'(MAXBURST);

    drain_state_t    state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic            flush_q, flush_d;

    logic flush_pend;
    logic thr_hit;
    logic to_hit;
    logic trigger;
    logic start;
    logic timer_clr;
    logic timer_en;

    assign flush_pend = flush_q || i_flush;
    assign thr_hit    = (i_threshold != '0) && (i_fill >= i_threshold);
    assign trigger    = i_en && !i_empty && (thr_hit || to_hit || flush_pend);

    // Timer only runs while idle with data waiting and nothing else firing.
    assign timer_clr  = (state_q != S_IDLE) || i_empty || start;
    assign timer_en   = (state_q == S_IDLE) && !i_empty && !trigger;

    burst_idle_timer #(
        .W (LGTIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (timer_clr),
        .i_en      (timer_en),
        .i_limit   (i_timeout),
        .o_hit     (to_hit)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        flush_d = flush_pend;
        start   = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_last  = 1'b0;
        o_rd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    start   = 1'b1;
                    state_d = S_BURST;
                    flush_d = 1'b0;
                    len_d   = (i_fill >= MAXFILL) ? LENW'(MAXBURST) : i_fill[LENW-1:0];
                end
            end
            S_BURST: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                o_last  = (len_q == LENW'(1));
                // FIFO pops only on handshake, so the head word stays put while stalled.
                o_rd    = i_ready;
                if (i_ready) begin
                    len_d = len_q - LENW'(1);
                    if (len_q == LENW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            flush_q <= flush_d;
        end
    end

    assign o_data = i_fdata;

endmodule

// File: tb/tb_sfifo_burst_drain.sv
// Bench for sfifo_burst_drain: queue-based FIFO, rule-level reference model,
// directed scenarios followed by a randomized run.
module tb_sfifo_burst_drain;

    localparam int BW = 8, LGFLEN = 4, LGMAXBURST = 2, LGTIMEOUT = 8;
    localparam int DEPTH = 1 << LGFLEN;
    localparam int MAXB  = 1 << LGMAXBURST;

    logic                 i_clk = 1'b0;
    logic                 i_reset_n;
    logic                 i_en;
    logic [LGFLEN:0]      i_threshold;
    logic [LGTIMEOUT-1:0] i_timeout;
    logic                 i_flush;
    logic [LGFLEN:0]      i_fill;
    logic                 i_empty;
    logic [BW-1:0]        i_fdata;
    logic                 o_rd;
    logic                 o_valid;
    logic                 i_ready;
    logic [BW-1:0]        o_data;
    logic                 o_last;
    logic                 o_busy;

    sfifo_burst_drain #(
        .BW(BW), .LGFLEN(LGFLEN), .LGMAXBURST(LGMAXBURST), .LGTIMEOUT(LGTIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_threshold(i_threshold),
        .i_timeout(i_timeout), .i_flush(i_flush), .i_fill(i_fill), .i_empty(i_empty),
        .i_fdata(i_fdata), .o_rd(o_rd), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] fq[$];
    logic          wr;
    logic [BW-1:0] wdata;

    // Reference model state
    bit m_burst, m_fpend;
    int m_rem, m_idle;

    // Observation records
    int lens[$];
    int cur_beats, n_rd;
    bit seen_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        bit e_valid, e_last, e_rd, pend, trig;
        int fill;
        fill      = fq.size();
        i_fill    = (LGFLEN + 1)'(fill);
        i_empty   = (fill == 0);
        i_fdata   = (fill == 0) ? '0 : fq[0];
        #1;
        e_valid = m_burst;
        e_last  = m_burst && (m_rem == 1);
        e_rd    = m_burst && i_ready;
        chk("valid", 32'(o_valid), 32'(e_valid));
        chk("busy",  32'(o_busy),  32'(e_valid));
        chk("last",  32'(o_last),  32'(e_last));
        chk("rd",    32'(o_rd),    32'(e_rd));
        if (e_valid && fill > 0) chk("data", 32'(o_data), 32'(fq[0]));
        seen_valid = o_valid;
        if (o_rd) n_rd++;
        if (o_valid && i_ready) begin
            cur_beats++;
            if (o_last) begin
                lens.push_back(cur_beats);
                cur_beats = 0;
            end
        end
        @(posedge i_clk);
        if (!i_reset_n) begin
            m_burst = 0; m_rem = 0; m_idle = 0; m_fpend = 0; cur_beats = 0;
        end else if (m_burst) begin
            m_idle = 0;
            if (i_flush) m_fpend = 1;
            if (i_ready) begin
                m_rem--;
                if (m_rem == 0) m_burst = 0;
            end
        end else begin
            pend = m_fpend || i_flush;
            trig = i_en && (fill != 0) &&
                   ((i_threshold != 0 && fill >= int'(i_threshold)) ||
                    (i_timeout != 0 && m_idle == int'(i_timeout)) || pend);
            if (trig) begin
                m_burst = 1;
                m_rem   = (fill < MAXB) ? fill : MAXB;
                m_idle  = 0;
                m_fpend = 0;
            end else begin
                m_fpend = pend;
                if (fill == 0) m_idle = 0;
                else if (m_idle < int'(i_timeout)) m_idle++;
            end
        end
        if (e_rd && fq.size() > 0) void'(fq.pop_front());
        if (wr && fq.size() < DEPTH) fq.push_back(wdata);
        @(negedge i_clk);
        wr = 0;
        i_flush = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic write_words(input int n);
        for (int k = 0; k < n; k++) begin
            wr = 1;
            wdata = BW'($urandom);
            cycle();
        end
    endtask

    task automatic check_lens(input string tag, input int n, input int a, input int b);
        chk({tag, "_nbursts"}, 32'(lens.size()), 32'(n));
        if (n > 0 && lens.size() > 0) chk({tag, "_len0"}, 32'(lens[0]), 32'(a));
        if (n > 1 && lens.size() > 1) chk({tag, "_len1"}, 32'(lens[1]), 32'(b));
        lens.delete();
    endtask

    initial begin
        bit found;
        int lat;
        wr = 0; wdata = '0; i_reset_n = 0; i_en = 1; i_threshold = '0; i_timeout = '0;
        i_flush = 0; i_ready = 1; i_fill = '0; i_empty = 1; i_fdata = '0;
        m_burst = 0; m_fpend = 0; m_rem = 0; m_idle = 0; cur_beats = 0; n_rd = 0;
        repeat (2) @(negedge i_clk);
        run(2);                             // reset state checked by the model
        i_reset_n = 1;

        // Threshold burst of 4
        i_threshold = 4; i_timeout = 0;
        write_words(4);
        run(10);
        check_lens("t1", 1, 4, 0);
        chk("t1_fifo_empty", 32'(fq.size()), 0);

        // Timeout-driven partial burst of 3
        i_threshold = 0; i_timeout = 10;
        found = 0; lat = 0;
        wr = 1; wdata = BW'($urandom); cycle();
        for (int k = 0; k < 40 && !found; k++) begin
            wr = (k < 2); wdata = BW'($urandom);
            cycle();
            if (seen_valid) begin found = 1; lat = k + 1; end
        end
        chk("t2_found", 32'(found), 1);
        chk("t2_latency", 32'(lat), 12);    // 10 idle counts, trigger, then valid
        run(8);
        check_lens("t2", 1, 3, 0);

        // Fill beyond max burst: two back-to-back bursts of 4
        i_en = 0; i_threshold = 4; i_timeout = 0;
        write_words(8);
        i_en = 1;
        run(14);
        check_lens("t3", 2, 4, 4);
        chk("t3_fifo_empty", 32'(fq.size()), 0);

        // Backpressure: ready alternating
        n_rd = 0;
        write_words(4);
        for (int k = 0; k < 20; k++) begin
            i_ready = (k % 2 == 0);
            cycle();
        end
        i_ready = 1;
        chk("t4_rd_pulses", 32'(n_rd), 4);
        check_lens("t4", 1, 4, 0);

        // Flush with 2 words, then pending flush while empty
        i_threshold = 8;
        write_words(2);
        run(3);
        chk("t5_no_burst", 32'(lens.size()), 0);
        i_flush = 1;
        run(8);
        check_lens("t5a", 1, 2, 0);
        i_flush = 1;
        run(3);
        write_words(1);
        run(6);
        check_lens("t5b", 1, 1, 0);

        // Reset mid-burst after 2 beats, then i_en=0 blocks triggers
        i_threshold = 4; n_rd = 0;
        write_words(4);
        for (int k = 0; k < 20 && n_rd < 2; k++) cycle();
        chk("t6_two_beats", 32'(n_rd), 2);
        i_ready = 0; i_reset_n = 0;
        cycle();
        i_reset_n = 1; i_ready = 1; i_en = 0; i_threshold = 1;
        cycle();
        chk("t6_valid_after_reset", 32'(o_valid), 0);
        chk("t6_fifo_kept", 32'(fq.size()), 2);
        n_rd = 0;
        run(10);
        chk("t6_blocked_rd", 32'(n_rd), 0);
        chk("t6_blocked_lens", 32'(lens.size()), 0);
        i_en = 1;
        run(8);
        check_lens("t6", 1, 2, 0);
        chk("t6_fifo_empty", 32'(fq.size()), 0);

        // Randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                i_threshold = (LGFLEN + 1)'($urandom_range(0, 10));
                i_timeout   = LGTIMEOUT'($urandom_range(0, 12));
            end
            i_en      = ($urandom_range(0, 9) != 0);
            i_ready   = ($urandom_range(0, 9) < 7);
            i_flush   = ($urandom_range(0, 19) == 0);
            i_reset_n = ($urandom_range(0, 199) != 0);
            wr        = ($urandom_range(0, 9) < 4);
            wdata     = BW'($urandom);
            cycle();
        end
        i_reset_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
